// File: rtl/seq_gen_sched.sv
// Round-robin front end sharing one sequence engine; grant -> eng_clr next cycle -> first beat the cycle after.
// Beats hold stable while out_ready is low; the engine only steps on an accepted beat.
module seq_gen_sched #(
  parameter int DataBus = 32,
  parameter int NUM_REQ = 4,
  parameter int LenW    = 8,
  parameter int IdW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LenW-1:0]  req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     eng_clr,
  output logic                     eng_step,
  input  logic [DataBus-1:0]       eng_seq,
  output logic                     out_valid,
  output logic [DataBus-1:0]       out_data,
  output logic [IdW-1:0]           out_id,
  output logic                     out_last,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IdW-1:0]  rr_ptr;
  logic [IdW-1:0]  cur_id;
  logic [LenW-1:0] cnt;
  logic [IdW-1:0]  grant_id;
  logic [LenW-1:0] grant_len;
  logic            grant_any;
  logic            xfer;
  logic [IdW:0]    scan_idx;

  // Scan from the highest offset down so the closest set bit at/after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (IdW+1)'(k);
      if (scan_idx >= (IdW+1)'(NUM_REQ))
        scan_idx = scan_idx - (IdW+1)'(NUM_REQ);
      if (req_valid[scan_idx[IdW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx[IdW-1:0];
      end
    end
  end

  assign grant_len = req_len[grant_id*LenW +: LenW];
  assign xfer      = (state == STREAM) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    eng_clr   = 1'b0;
    eng_step  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_id    = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        // Reset gating keeps the accept pulse quiet while reset is held.
        if (grant_any && !reset) begin
          req_ready[grant_id] = 1'b1;
          if (grant_len != '0)
            state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        eng_clr   = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = eng_seq;
        out_id    = cur_id;
        out_last  = (cnt == LenW'(1));
        eng_step  = out_ready;
        if (out_ready && cnt == LenW'(1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-length grant still latches and moves the pointer, but never leaves IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      cur_id <= '0;
      cnt    <= '0;
    end else if (state == IDLE && grant_any) begin
      cur_id <= grant_id;
      cnt    <= grant_len;
      rr_ptr <= (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);
    end else if (xfer) begin
      cnt <= cnt - LenW'(1);
    end
  end

endmodule

// File: doc/seq_gen_sched.md
Name: seq_gen_sched

Overview:
- Round-robin scheduler that shares one sequence-generator engine between NUM_REQ requesters.
- Each requester asks for a burst of N consecutive terms starting from the sequence origin.
- The scheduler grants one request at a time, restarts the engine, steps it once per accepted output beat, and tags each beat with the requester ID.
- It sits between the engine and its consumers; the engine provides a synchronous clear and a step enable.

Parameters:
- DataBus, 32, width of sequence terms.
- NUM_REQ, 4, number of requesters (2..16).
- LenW, 8, width of the burst-length field.
- IdW, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request pending.
- req_len  input  NUM_REQ*LenW  packed burst lengths; requester i uses bits [i*LenW +: LenW].
- req_ready  output  NUM_REQ  one-hot accept pulse, combinational.
- eng_clr  output  1  synchronous clear of the engine to its initial state.
- eng_step  output  1  advance the engine by one term.
- eng_seq  input  DataBus  current engine term (engine output).
- out_valid  output  1  output beat valid.
- out_data  output  DataBus  sequence term.
- out_id  output  IdW  requester index owning the beat.
- out_last  output  1  final beat of the burst.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Reset forces: state IDLE, rr_ptr=0, out_valid=0, out_last=0, out_id=0, out_data=0, eng_clr=0, eng_step=0, req_ready=0.
- Reset asserted mid-burst drops out_valid immediately and abandons the burst. No completion is signalled.
- FSM states: IDLE, CLEAR, STREAM.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 that cycle only; req_len[g] and g are latched into cnt and cur_id.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - If the latched length is nonzero, go to CLEAR. If it is 0, the request is accepted and discarded: stay IDLE, no engine activity, no beats, pointer still advances.
  - With no req_valid, stay IDLE and hold all outputs at 0.
- CLEAR: eng_clr=1 for exactly one cycle, then go to STREAM.
- STREAM:
  - out_valid=1, out_data=eng_seq, out_id=cur_id, out_last=(cnt==1).
  - On out_valid && out_ready: eng_step=1 and cnt decrements.
  - If out_last is set on that transfer, go to IDLE.
  - With out_ready=0: hold all outputs stable, eng_step=0, no decrement (no data loss, no re-step).
- Outside STREAM, out_data is driven 0; out_id and out_last are 0 unless out_valid=1.
- eng_step is asserted only in STREAM on a transfer; eng_clr only in CLEAR. Both are never high together.
- Latency: request accepted at cycle T -> eng_clr at T+1 -> first out_valid at T+2.
  - Last transfer at cycle L -> IDLE at L+1, earliest next grant at L+1, next first beat at L+3.
- Requesters must hold req_valid and req_len stable until req_ready. Deasserting req_valid before grant withdraws the request.
- Requests arriving during CLEAR or STREAM wait. req_ready stays 0 outside IDLE.
- Burst length range is 1..2^LenW-1 beats. cnt is LenW bits and never wraps.
- Arithmetic is performed only by the engine; the scheduler passes terms through unmodified at DataBus width.
- Engine contract: after eng_clr, eng_seq yields 0,1,1,1,2,2,3,4,5,7,9,12,... with one term per eng_step. Terms wrap modulo 2^DataBus.

Test Plan:
- Single burst: req_valid=4'b0001, len0=5, out_ready=1 -> req_ready[0] at T, eng_clr at T+1, beats T+2..T+6 with data 0,1,1,1,2, out_id=0, out_last only on the fifth beat, then IDLE.
- Round-robin: all four requesters valid with len=2 each, held until accepted -> grant order 0,1,2,3. Re-raise all four -> order 0,1,2,3 again. Each burst yields data 0,1 with the correct out_id.
- Backpressure: len=4, out_ready toggles 1,0,0,1,1,0,1 -> data sequence 0,1,1,1 with no skips or duplicates. eng_step count equals 4 and occurs only on transfer cycles.
- Zero length: req 2 with len=0, req 3 with len=3 -> req_ready[2] pulses, no beats for ID 2. Next cycle req 3 is granted and produces 0,1,1 with out_id=3.
- Reset mid-burst: len=10, assert reset after the third beat -> out_valid=0 immediately, outputs at reset values. After release, a new len=2 request restarts from data 0,1 via eng_clr.
- Long burst: len=255, golden engine model -> 255 beats matching the reference sequence. out_last only on beat 255, with no extra eng_step after it.
